// File: rtl/dma_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dma_mem_ctrl
//  Brief    : SRAM port owner shared between the Z80 bus and the DMA engines.
//             Runs one SRAM cycle per accepted DMA request. A request is only
//             accepted while the CPU is off the bus, and bursts are capped so
//             that the CPU always gets a bus window.
//  Revision : 1.0 - initial release
// ============================================================================
module dma_mem_ctrl #(
    parameter int WAIT_STATES = 1,  // extra strobe cycles per access (0..7)
    parameter int MAX_BURST   = 4   // accepts before a forced CPU gap (1..15)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_req,
    input  logic        dma_rnw,
    input  logic [20:0] dma_addr,
    input  logic [7:0]  dma_wd,
    output logic [7:0]  dma_rd,
    output logic        dma_ack,
    output logic        dma_end,
    input  logic        cpu_mem,
    output logic        mem_dma,
    output logic [20:0] mem_addr,
    output logic [7:0]  mem_wd,
    input  logic [7:0]  mem_rd,
    output logic        mem_oe_n,
    output logic        mem_we_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        END    = 2'd2
    } state_t;

    localparam logic [2:0] c_wait_init = 3'(WAIT_STATES);
    localparam logic [3:0] c_burst_cap = 4'(MAX_BURST);

    state_t      r_state;
    logic [2:0]  r_wcnt;
    logic [3:0]  r_bcnt;
    logic        r_rnw;
    logic [7:0]  r_rd;
    logic        r_mem_dma;
    logic [20:0] r_mem_addr;
    logic [7:0]  r_mem_wd;
    logic        r_oe_n;
    logic        r_we_n;
    logic        w_accept;

    // Accept decode: free slot (IDLE or END), CPU off the bus, burst not capped
    assign w_accept = rst_n
                    & ((r_state == IDLE) | (r_state == END))
                    & dma_req
                    & ~cpu_mem
                    & (r_bcnt != c_burst_cap);

    assign dma_ack  = w_accept;
    assign dma_end  = (r_state == END);
    assign dma_rd   = r_rd;
    assign mem_dma  = r_mem_dma;
    assign mem_addr = r_mem_addr;
    assign mem_wd   = r_mem_wd;
    assign mem_oe_n = r_oe_n;
    assign mem_we_n = r_we_n;

    // Sequencer: accept, hold strobes for 1+WAIT_STATES cycles, then END
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wcnt     <= 3'd0;
            r_bcnt     <= 4'd0;
            r_rnw      <= 1'b1;
            r_rd       <= 8'd0;
            r_mem_dma  <= 1'b0;
            r_mem_addr <= 21'd0;
            r_mem_wd   <= 8'd0;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
        end else begin
            case (r_state)
                IDLE, END: begin
                    if (w_accept) begin
                        // Inputs are sampled here; END may overlap a new accept
                        r_mem_addr <= dma_addr;
                        r_mem_wd   <= dma_wd;
                        r_rnw      <= dma_rnw;
                        r_mem_dma  <= 1'b1;
                        r_oe_n     <= ~dma_rnw;
                        r_we_n     <= dma_rnw;
                        r_wcnt     <= c_wait_init;
                        r_bcnt     <= r_bcnt + 4'd1;
                        r_state    <= ACCESS;
                    end else begin
                        // Any free cycle without an accept ends the burst
                        r_bcnt  <= 4'd0;
                        r_state <= IDLE;
                    end
                end
                ACCESS: begin
                    // cpu_mem and dma_req are ignored; the cycle always completes
                    if (r_wcnt != 3'd0) begin
                        r_wcnt <= r_wcnt - 3'd1;
                    end else begin
                        if (r_rnw) begin
                            r_rd <= mem_rd;
                        end
                        r_oe_n    <= 1'b1;
                        r_we_n    <= 1'b1;
                        r_mem_dma <= 1'b0;
                        r_state   <= END;
                    end
                end
                default: begin
                    r_oe_n    <= 1'b1;
                    r_we_n    <= 1'b1;
                    r_mem_dma <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dma_mem_ctrl
//  Brief    : Self-checking bench for dma_mem_ctrl. Instance A uses one wait
//             state with a burst cap of 4; instance B uses zero wait states.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dma_mem_ctrl;

    localparam int A_WS = 1;
    localparam int A_MB = 4;
    localparam int B_WS = 0;
    localparam int B_MB = 15;

    logic clk;
    logic rst_n;

    logic        a_req, a_rnw, a_cpu;
    logic [20:0] a_addr;
    logic [7:0]  a_wd, a_mrd;
    logic [7:0]  a_rd;
    logic        a_ack, a_end, a_mdma, a_oe, a_we;
    logic [20:0] a_maddr;
    logic [7:0]  a_mwd;

    logic        b_req, b_rnw, b_cpu;
    logic [20:0] b_addr;
    logic [7:0]  b_wd, b_mrd;
    logic [7:0]  b_rd;
    logic        b_ack, b_end, b_mdma, b_oe, b_we;
    logic [20:0] b_maddr;
    logic [7:0]  b_mwd;

    int n_chk;
    int n_pass;

    dma_mem_ctrl #(.WAIT_STATES(A_WS), .MAX_BURST(A_MB)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .dma_req(a_req), .dma_rnw(a_rnw), .dma_addr(a_addr), .dma_wd(a_wd),
        .dma_rd(a_rd), .dma_ack(a_ack), .dma_end(a_end), .cpu_mem(a_cpu),
        .mem_dma(a_mdma), .mem_addr(a_maddr), .mem_wd(a_mwd), .mem_rd(a_mrd),
        .mem_oe_n(a_oe), .mem_we_n(a_we)
    );

    dma_mem_ctrl #(.WAIT_STATES(B_WS), .MAX_BURST(B_MB)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .dma_req(b_req), .dma_rnw(b_rnw), .dma_addr(b_addr), .dma_wd(b_wd),
        .dma_rd(b_rd), .dma_ack(b_ack), .dma_end(b_end), .cpu_mem(b_cpu),
        .mem_dma(b_mdma), .mem_addr(b_maddr), .mem_wd(b_mwd), .mem_rd(b_mrd),
        .mem_oe_n(b_oe), .mem_we_n(b_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive phase: just after the active edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_req = 0; a_rnw = 1; a_cpu = 0; a_addr = '0; a_wd = '0; a_mrd = '0;
        b_req = 0; b_rnw = 1; b_cpu = 0; b_addr = '0; b_wd = '0; b_mrd = '0;
        next_cycle();
        next_cycle();
        a_req = 1;
        @(negedge clk);
        n_chk++; if (a_ack !== 1'b0) $display("FAIL reset_ack: got %b exp 0", a_ack); else n_pass++;
        n_chk++; if (a_end !== 1'b0) $display("FAIL reset_end: got %b exp 0", a_end); else n_pass++;
        n_chk++; if (a_rd !== 8'h00) $display("FAIL reset_rd: got %h exp 00", a_rd); else n_pass++;
        n_chk++; if (a_mdma !== 1'b0) $display("FAIL reset_mdma: got %b exp 0", a_mdma); else n_pass++;
        n_chk++; if ({a_oe, a_we} !== 2'b11) $display("FAIL reset_strobes: got %b exp 11", {a_oe, a_we}); else n_pass++;
        n_chk++; if (a_maddr !== 21'd0) $display("FAIL reset_maddr: got %h exp 0", a_maddr); else n_pass++;
        n_chk++; if (a_mwd !== 8'd0) $display("FAIL reset_mwd: got %h exp 0", a_mwd); else n_pass++;
        a_req = 0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        next_cycle();
    endtask

    // One isolated access on A, checking the full cycle-by-cycle timeline
    task automatic test_single(input bit rnw, input logic [20:0] addr,
                               input logic [7:0] wd, input logic [7:0] mrd,
                               input logic [7:0] exp_rd);
        a_req = 1; a_rnw = rnw; a_addr = addr; a_wd = wd; a_mrd = mrd; a_cpu = 0;
        @(negedge clk);
        n_chk++; if (a_ack !== 1'b1) $display("FAIL single_ack_t0: got %b exp 1", a_ack); else n_pass++;
        next_cycle();
        a_req = 0;
        for (int c = 1; c <= 2 + A_WS; c++) begin
            bit strobe;
            strobe = (c <= 1 + A_WS);
            @(negedge clk);
            n_chk++; if (a_ack !== 1'b0) $display("FAIL single_ack c%0d: got %b exp 0", c, a_ack); else n_pass++;
            n_chk++; if (a_end !== (c == 2 + A_WS)) $display("FAIL single_end c%0d: got %b exp %b", c, a_end, (c == 2 + A_WS)); else n_pass++;
            n_chk++; if (a_oe !== !(strobe && rnw)) $display("FAIL single_oe c%0d: got %b exp %b", c, a_oe, !(strobe && rnw)); else n_pass++;
            n_chk++; if (a_we !== !(strobe && !rnw)) $display("FAIL single_we c%0d: got %b exp %b", c, a_we, !(strobe && !rnw)); else n_pass++;
            n_chk++; if (a_mdma !== strobe) $display("FAIL single_mdma c%0d: got %b exp %b", c, a_mdma, strobe); else n_pass++;
            if (strobe) begin
                n_chk++; if (a_maddr !== addr) $display("FAIL single_maddr c%0d: got %h exp %h", c, a_maddr, addr); else n_pass++;
                n_chk++; if (a_mwd !== wd) $display("FAIL single_mwd c%0d: got %h exp %h", c, a_mwd, wd); else n_pass++;
            end
            if (c == 2 + A_WS) begin
                n_chk++; if (a_rd !== exp_rd) $display("FAIL single_rd: got %h exp %h", a_rd, exp_rd); else n_pass++;
            end
            next_cycle();
        end
    endtask

    // Held request with WAIT_STATES=1, MAX_BURST=4: acks 0,3,6,9 then 13
    task automatic test_back_to_back();
        a_req = 1; a_rnw = 1; a_addr = 21'h00100; a_mrd = 8'h77; a_cpu = 0;
        for (int c = 0; c <= 16; c++) begin
            bit e_ack, e_end;
            if (c == 14) a_req = 0;
            e_ack = ((c % 3 == 0) && c <= 9) || c == 13;
            e_end = ((c % 3 == 0) && c >= 3 && c <= 12) || c == 16;
            @(negedge clk);
            n_chk++; if (a_ack !== e_ack) $display("FAIL burst_ack c%0d: got %b exp %b", c, a_ack, e_ack); else n_pass++;
            n_chk++; if (a_end !== e_end) $display("FAIL burst_end c%0d: got %b exp %b", c, a_end, e_end); else n_pass++;
            next_cycle();
        end
        next_cycle();
    endtask

    // CPU holds off DMA; CPU activity during ACCESS does not abort the cycle
    task automatic test_cpu_block();
        a_req = 1; a_rnw = 0; a_addr = 21'h0ABCD; a_wd = 8'h3C; a_cpu = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_chk++; if (a_ack !== 1'b0) $display("FAIL cpu_block_ack c%0d: got %b exp 0", c, a_ack); else n_pass++;
            n_chk++; if (a_mdma !== 1'b0) $display("FAIL cpu_block_mdma c%0d: got %b exp 0", c, a_mdma); else n_pass++;
            next_cycle();
        end
        a_cpu = 0;
        @(negedge clk);
        n_chk++; if (a_ack !== 1'b1) $display("FAIL cpu_release_ack: got %b exp 1", a_ack); else n_pass++;
        next_cycle();
        a_req = 0; a_cpu = 1;
        for (int c = 1; c <= 2 + A_WS; c++) begin
            @(negedge clk);
            n_chk++; if (a_we !== (c == 2 + A_WS)) $display("FAIL cpu_mid_we c%0d: got %b exp %b", c, a_we, (c == 2 + A_WS)); else n_pass++;
            n_chk++; if (a_end !== (c == 2 + A_WS)) $display("FAIL cpu_mid_end c%0d: got %b exp %b", c, a_end, (c == 2 + A_WS)); else n_pass++;
            next_cycle();
        end
        a_cpu = 0;
        next_cycle();
    endtask

    // Asynchronous reset in the middle of an access
    task automatic test_reset_mid();
        a_req = 1; a_rnw = 1; a_addr = 21'h1F00F; a_mrd = 8'h99; a_cpu = 0;
        @(negedge clk);
        n_chk++; if (a_ack !== 1'b1) $display("FAIL rstmid_ack: got %b exp 1", a_ack); else n_pass++;
        next_cycle();
        a_req = 0;
        @(negedge clk);
        n_chk++; if (a_oe !== 1'b0) $display("FAIL rstmid_oe_before: got %b exp 0", a_oe); else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_chk++; if ({a_oe, a_we} !== 2'b11) $display("FAIL rstmid_strobes: got %b exp 11", {a_oe, a_we}); else n_pass++;
        n_chk++; if (a_mdma !== 1'b0) $display("FAIL rstmid_mdma: got %b exp 0", a_mdma); else n_pass++;
        next_cycle();
        @(negedge clk);
        n_chk++; if (a_end !== 1'b0) $display("FAIL rstmid_end_in_reset: got %b exp 0", a_end); else n_pass++;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            n_chk++; if (a_end !== 1'b0) $display("FAIL rstmid_no_end c%0d: got %b exp 0", c, a_end); else n_pass++;
        end
        next_cycle();
        test_single(1'b0, 21'h12345, 8'hA5, 8'h11, 8'h00);
    endtask

    // WAIT_STATES=0 stream: ack every 2 cycles, end overlapping the next ack
    task automatic test_ws0_stream();
        logic [7:0] rdv [0:15];
        for (int i = 0; i < 16; i++) rdv[i] = 8'($urandom);
        b_req = 1; b_rnw = 1; b_addr = 21'h00042; b_cpu = 0;
        for (int c = 0; c <= 12; c++) begin
            bit e_ack, e_end;
            b_mrd = rdv[c];
            if (c == 11) b_req = 0;
            e_ack = (c % 2 == 0) && c <= 10;
            e_end = (c % 2 == 0) && c >= 2;
            @(negedge clk);
            n_chk++; if (b_ack !== e_ack) $display("FAIL ws0_ack c%0d: got %b exp %b", c, b_ack, e_ack); else n_pass++;
            n_chk++; if (b_end !== e_end) $display("FAIL ws0_end c%0d: got %b exp %b", c, b_end, e_end); else n_pass++;
            n_chk++; if (b_mdma !== (c % 2 == 1)) $display("FAIL ws0_mdma c%0d: got %b exp %b", c, b_mdma, (c % 2 == 1)); else n_pass++;
            if (e_end) begin
                n_chk++; if (b_rd !== rdv[c-1]) $display("FAIL ws0_rd c%0d: got %h exp %h", c, b_rd, rdv[c-1]); else n_pass++;
            end
            next_cycle();
        end
    endtask

    // Random traffic on A against a timeline model of the access rules
    task automatic test_random();
        int          last_ack = -100;
        int          t_free = 0;
        int          burst = 0;
        bit          pend = 0;
        bit          l_rnw = 1;
        logic [20:0] l_addr = '0;
        logic [7:0]  l_wd = '0;
        logic [7:0]  exp_rd = 8'h00;
        rst_n = 1'b0;
        a_req = 0; a_cpu = 0;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        for (int c = 0; c < 600; c++) begin
            bit e_ack, in_str, e_end;
            if (!pend) begin
                if ($urandom_range(0, 3) != 0) begin
                    pend = 1; a_req = 1;
                    a_rnw = 1'($urandom); a_addr = 21'($urandom); a_wd = 8'($urandom);
                end else begin
                    a_req = 0;
                end
            end
            a_cpu = ($urandom_range(0, 3) == 0);
            a_mrd = 8'($urandom);
            @(negedge clk);
            e_ack  = pend && (c >= t_free) && !a_cpu && (burst < A_MB);
            in_str = (c >= last_ack + 1) && (c <= last_ack + 1 + A_WS);
            e_end  = (c == last_ack + 2 + A_WS);
            n_chk++; if (a_ack !== e_ack) $display("FAIL rnd_ack c%0d: got %b exp %b", c, a_ack, e_ack); else n_pass++;
            n_chk++; if (a_end !== e_end) $display("FAIL rnd_end c%0d: got %b exp %b", c, a_end, e_end); else n_pass++;
            n_chk++; if (a_oe !== !(in_str && l_rnw)) $display("FAIL rnd_oe c%0d: got %b exp %b", c, a_oe, !(in_str && l_rnw)); else n_pass++;
            n_chk++; if (a_we !== !(in_str && !l_rnw)) $display("FAIL rnd_we c%0d: got %b exp %b", c, a_we, !(in_str && !l_rnw)); else n_pass++;
            n_chk++; if (a_mdma !== in_str) $display("FAIL rnd_mdma c%0d: got %b exp %b", c, a_mdma, in_str); else n_pass++;
            n_chk++; if (a_rd !== exp_rd) $display("FAIL rnd_rd c%0d: got %h exp %h", c, a_rd, exp_rd); else n_pass++;
            if (in_str) begin
                n_chk++; if (a_maddr !== l_addr) $display("FAIL rnd_maddr c%0d: got %h exp %h", c, a_maddr, l_addr); else n_pass++;
                n_chk++; if (a_mwd !== l_wd) $display("FAIL rnd_mwd c%0d: got %h exp %h", c, a_mwd, l_wd); else n_pass++;
            end
            // Read data is captured on the last strobe cycle
            if (c == last_ack + 1 + A_WS && l_rnw) exp_rd = a_mrd;
            if (e_ack) begin
                last_ack = c; t_free = c + 2 + A_WS; burst++;
                l_rnw = a_rnw; l_addr = a_addr; l_wd = a_wd; pend = 0;
            end else if (c >= t_free) begin
                burst = 0;
            end
            next_cycle();
        end
        a_req = 0; a_cpu = 0;
        for (int i = 0; i < 4; i++) next_cycle();
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        test_reset();
        test_single(1'b1, 21'h1ABCD, 8'h00, 8'h5A, 8'h5A);
        test_single(1'b0, 21'h00010, 8'hC3, 8'hEE, 8'h5A);
        test_back_to_back();
        test_cpu_block();
        test_reset_mid();
        test_ws0_stream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/dma_mem_ctrl.md
Name: dma_mem_ctrl

Overview:
- Owns the single SRAM port shared by the Z80 bus and the DMA engines.
- Sits below the DMA sequencer. Takes its merged request (dma_req/dma_rnw/dma_addr/dma_wd) and runs one SRAM cycle per request.
- Returns a dma_ack pulse when a request is accepted and a dma_end pulse when that cycle finishes.
- Grants DMA only when the CPU is not using memory, and caps back-to-back DMA bursts so the CPU always gets a bus window.

Parameters:
- WAIT_STATES, 1, extra SRAM strobe cycles per access (0..7).
- MAX_BURST, 4, maximum consecutive DMA accepts before a forced one-cycle CPU gap (1..15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- dma_req  in  1  OR of all requester requests; held until dma_ack.
- dma_rnw  in  1  1 = read, 0 = write; valid while dma_req.
- dma_addr  in  21  byte address; valid while dma_req.
- dma_wd  in  8  write data; valid while dma_req.
- dma_rd  out  8  read data; updated at dma_end of read cycles only.
- dma_ack  out  1  one-cycle accept pulse; inputs are sampled on this edge.
- dma_end  out  1  one-cycle completion pulse.
- cpu_mem  in  1  Z80 memory cycle in progress this clock.
- mem_dma  out  1  SRAM mux select: 1 = DMA drives the SRAM port.
- mem_addr  out  21  SRAM address (registered).
- mem_wd  out  8  SRAM write data (registered).
- mem_rd  in  8  SRAM read data.
- mem_oe_n  out  1  SRAM output enable, active-low.
- mem_we_n  out  1  SRAM write enable, active-low.

Behaviour:
- States: IDLE, ACCESS, END. Wait counter wcnt is 3 bits. Burst counter bcnt is 4 bits.
- Reset values: state=IDLE, dma_ack=0, dma_end=0, dma_rd=0, mem_dma=0, mem_oe_n=1, mem_we_n=1, mem_addr=0, mem_wd=0, bcnt=0, wcnt=0.
- Accept condition:
  - accept = rst_n & (state==IDLE | state==END) & dma_req & !cpu_mem & (bcnt!=MAX_BURST).
  - dma_ack = accept. It is a combinational decode of registered state and inputs, and is forced 0 while rst_n is low.
- On the accept edge:
  - mem_addr<=dma_addr, mem_wd<=dma_wd; latch rnw.
  - mem_dma<=1; mem_oe_n<=!rnw; mem_we_n<=rnw.
  - wcnt<=WAIT_STATES; state->ACCESS; bcnt<=bcnt+1.
- ACCESS:
  - Strobes are held.
  - If wcnt!=0: wcnt<=wcnt-1, stay in ACCESS.
  - Else: on a read, dma_rd<=mem_rd. Strobes deassert (oe_n=1, we_n=1), mem_dma<=0, state->END.
  - Total strobe length is 1+WAIT_STATES cycles.
- END:
  - dma_end=1 for exactly this cycle (registered: dma_end = state==END).
  - If accept: go back to ACCESS, so ack and end coincide. This overlap is legal and required, because the sequencer routes done by the previously acked device.
  - Else: state->IDLE.
- Latency: ack at cycle T, strobe T+1..T+1+WAIT_STATES, dma_end at T+2+WAIT_STATES. Back-to-back period is 2+WAIT_STATES.
- Burst cap: bcnt clears in any cycle where the block is in IDLE or END without an accept. At bcnt==MAX_BURST, accept is blocked for at least one cycle; bcnt then clears and arbitration resumes.
- cpu_mem is sampled only for accept. Asserting it during ACCESS does not abort the cycle. The CPU side must use mem_dma to stall.
- dma_req dropping during ACCESS has no effect; the cycle completes.
- Writes leave dma_rd unchanged. dma_rd holds its value between reads.
- Reset mid-cycle: immediate return to IDLE, strobes high, mem_dma=0. No dma_end is generated for the aborted cycle.
- mem_addr/mem_wd are stable throughout ACCESS, and the strobes never overlap.

Test Plan:
1. WAIT_STATES=1: single read of addr 0x1ABCD, cpu_mem=0, mem_rd=0x5A -> ack at T0, oe_n low T1-T2, dma_end at T3, dma_rd=0x5A, we_n stays 1.
2. Single write of addr 0x00010, data 0xC3 -> we_n low for 2 cycles, mem_addr=0x00010, mem_wd=0xC3, dma_end at T3, dma_rd unchanged.
3. dma_req held high with MAX_BURST=4 -> 4 acks at T0/T3/T6/T9, the 4th dma_end at T12 carries no ack, next ack at T13.
4. cpu_mem=1 while dma_req=1 for 5 cycles -> no ack, mem_dma=0; ack in the first cycle cpu_mem=0. Then raise cpu_mem during ACCESS -> cycle still ends with dma_end.
5. rst_n low during ACCESS -> strobes high and mem_dma=0 asynchronously, no dma_end, state IDLE. After release, a new request is acked normally.
6. WAIT_STATES=0, continuous reads -> ack every 2 cycles, each dma_end coinciding with the next ack, dma_rd following mem_rd per access.
